// File: rtl/jk_excitation_driver.sv
// Drives a bank of WIDTH JK flip-flops toward a requested word, checking and retrying on mismatch.
// Optional build macro: JK_TOGGLE_EN selects toggle (J=K=1) excitation for changing bits.
module jk_excitation_driver #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [WIDTH-1:0] req_data_i,
   input  logic [WIDTH-1:0] q_fb_i,
   output logic [WIDTH-1:0] j_o,
   output logic [WIDTH-1:0] k_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   // Keep at least one bit so MAX_RETRY=0 still elaborates.
   localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  target_q, target_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic [WIDTH-1:0]  j_q, j_d, k_q, k_d;
   logic              done_q, done_d, err_q, err_d;

   function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_EN
      return q ^ t;
`else
      return ~q & t;
`endif
   endfunction

   function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_EN
      return q ^ t;
`else
      return q & ~t;
`endif
   endfunction

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      retry_d  = retry_q;
      j_d      = '0;
      k_d      = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               target_d = req_data_i;
               j_d      = exc_j(q_fb_i, req_data_i);
               k_d      = exc_k(q_fb_i, req_data_i);
               retry_d  = '0;
               state_d  = StDrive;
            end
         end
         StDrive: begin
            state_d = StCheck;
         end
         StCheck: begin
            if (q_fb_i == target_q) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (retry_q < RetryW'(MAX_RETRY)) begin
               retry_d = retry_q + RetryW'(1);
               j_d     = exc_j(q_fb_i, target_q);
               k_d     = exc_k(q_fb_i, target_q);
               state_d = StDrive;
            end else begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         target_q <= '0;
         retry_q  <= '0;
         j_q      <= '0;
         k_q      <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         retry_q  <= retry_d;
         j_q      <= j_d;
         k_q      <= k_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign j_o         = j_q;
   assign k_o         = k_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign busy_o      = (state_q != StIdle);
   assign req_ready_o = (state_q == StIdle);

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with a behavioural JK bank and a result scoreboard.
// Expected excitation values follow JK_TOGGLE_EN when the build defines it.
module tb_jk_excitation_driver;

`ifdef JK_TOGGLE_EN
   localparam bit Tog = 1'b1;
`else
   localparam bit Tog = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_data;
   logic [7:0] q_fb;
   logic [7:0] j, k;
   logic       busy, done, err;

   logic [7:0] bank;
   logic [7:0] stuck;
   logic       load_en;
   logic [7:0] load_val;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic       d;
      logic       e;
      logic [7:0] bank;
      logic [7:0] j1;
      logic [7:0] k1;
      int         pulses;
      int         cycles;
   } exp_t;

   exp_t sb[$];

   jk_excitation_driver #(
      .WIDTH     (8),
      .MAX_RETRY (3)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_data_i  (req_data),
      .q_fb_i      (q_fb),
      .j_o         (j),
      .k_o         (k),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   // JK characteristic equation; stuck bits read back as 0.
   always @(posedge clk) begin
      if (load_en) bank <= load_val & ~stuck;
      else         bank <= ((j & ~bank) | (~k & bank)) & ~stuck;
   end

   assign q_fb = bank;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_bank(input logic [7:0] v);
      @(negedge clk);
      load_en  = 1'b1;
      load_val = v;
      @(posedge clk);
      #1 load_en = 1'b0;
      @(negedge clk);
   endtask

   // Caller is at a negedge with the DUT idle.
   task automatic accept(input exp_t e, input logic [7:0] data, input bit noise);
      chk({e.tag, "_ready_at_accept"}, {31'b0, req_ready}, 32'd1);
      sb.push_back(e);
      req_valid = 1'b1;
      req_data  = data;
      @(posedge clk);
      #1;
      req_valid = noise;
      req_data  = ~data;
   endtask

   task automatic collect();
      exp_t e;
      int   pulses  = 0;
      int   n       = 0;
      bit   seen    = 1'b0;
      bit   overlap = 1'b0;
      logic [7:0] j1 = '0, k1 = '0;
      e = sb.pop_front();
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk);
         n = c;
         if (c == 1) begin
            j1 = j;
            k1 = k;
            chk({e.tag, "_no_pulse_in_drive"}, {30'b0, done, err}, 32'd0);
            chk({e.tag, "_busy_in_drive"}, {30'b0, busy, req_ready}, 32'd2);
         end
         if ((j | k) != 8'h00) pulses++;
         if ((j & k) != 8'h00) overlap = 1'b1;
         if (done || err) seen = 1'b1;
      end
      req_valid = 1'b0;
      chk({e.tag, "_result_seen"}, {31'b0, seen}, 32'd1);
      chk({e.tag, "_j_first"}, {24'b0, j1}, {24'b0, e.j1});
      chk({e.tag, "_k_first"}, {24'b0, k1}, {24'b0, e.k1});
      chk({e.tag, "_done"}, {31'b0, done}, {31'b0, e.d});
      chk({e.tag, "_err"}, {31'b0, err}, {31'b0, e.e});
      chk({e.tag, "_ready_with_result"}, {31'b0, req_ready}, 32'd1);
      chk({e.tag, "_bank"}, {24'b0, q_fb}, {24'b0, e.bank});
      chk({e.tag, "_pulses"}, pulses, e.pulses);
      chk({e.tag, "_cycles"}, n, e.cycles);
`ifndef JK_TOGGLE_EN
      chk({e.tag, "_no_jk_11"}, {31'b0, overlap}, 32'd0);
`endif
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_data  = 8'h00;
      load_en   = 1'b0;
      load_val  = 8'h00;
      stuck     = 8'h00;
      bank      = 8'h00;
      #2;
      chk("rst_jk", {16'b0, j, k}, 32'd0);
      chk("rst_flags", {29'b0, done, err, busy}, 32'd0);
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      #10 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_jk", {16'b0, j, k}, 32'd0);
      chk("post_rst_flags", {29'b0, done, err, busy}, 32'd0);
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

      // Set/reset drive 0x0F -> 0xF0.
      load_bank(8'h0F);
      accept('{"f0", 1'b1, 1'b0, 8'hF0, Tog ? 8'hFF : 8'hF0, Tog ? 8'hFF : 8'h0F, 1, 3},
             8'hF0, 1'b0);
      collect();

      // 0x3C -> 0x5A with REQ_VALID held high while busy.
      @(negedge clk);
      load_bank(8'h3C);
      accept('{"5a", 1'b1, 1'b0, 8'h5A, Tog ? 8'h66 : 8'h42, Tog ? 8'h66 : 8'h24, 1, 3},
             8'h5A, 1'b1);
      collect();

      // Back-to-back accept in the DONE cycle; target already matches.
      accept('{"same", 1'b1, 1'b0, 8'h5A, 8'h00, 8'h00, 0, 3}, 8'h5A, 1'b0);
      collect();

      // Stuck-at-0 bit: four attempts then ERR.
      @(negedge clk);
      stuck = 8'h01;
      load_bank(8'h00);
      accept('{"stuck", 1'b0, 1'b1, 8'h00, 8'h01, Tog ? 8'h01 : 8'h00, 4, 9}, 8'h01, 1'b0);
      collect();
      @(negedge clk);
      chk("stuck_err_one_cycle", {30'b0, done, err}, 32'd0);
      stuck = 8'h00;

      // Reset during DRIVE.
      load_bank(8'h00);
      req_valid = 1'b1;
      req_data  = 8'h55;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("mid_drive_j", {24'b0, j}, 32'h55);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_jk", {16'b0, j, k}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_bank_held", {24'b0, q_fb}, 32'd0);
      accept('{"aa", 1'b1, 1'b0, 8'hAA, 8'hAA, 8'h00, 1, 3}, 8'hAA, 1'b0);
      collect();

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Drives a bank of WIDTH JK flip-flops from the control side. It accepts a target word over a valid/ready handshake and derives per-bit J/K excitation from the bank's fed-back Q. It pulses the excitation for one cycle, then checks the bank output against the target and retries on mismatch. It sits between a control sequencer and any JK register bank, which samples J/K on the same clock.

## Interface
- WIDTH, 8: number of JK flip-flops driven.
- MAX_RETRY, 3: extra DRIVE attempts after a failed CHECK. 0 means a single attempt.
- CLK  input  1  clock. All state changes on the rising edge.
- RST  input  1  reset, asynchronous and active-high.
- REQ_VALID  input  1  target word on REQ_DATA is valid.
- REQ_READY  output  1  block can accept a request. Decoded as state == IDLE.
- REQ_DATA  input  WIDTH  requested bank value.
- Q_FB  input  WIDTH  Q outputs of the driven JK bank.
- J  output  WIDTH  registered J excitation to the bank.
- K  output  WIDTH  registered K excitation to the bank.
- BUSY  output  1  state != IDLE.
- DONE  output  1  one-cycle pulse: the bank matched the target.
- ERR  output  1  one-cycle pulse: retries exhausted without a match.

## Operation
- States: IDLE, DRIVE, CHECK.
- IDLE
  - REQ_READY=1.
  - On an edge with REQ_VALID=1:
    - latch TARGET=REQ_DATA;
    - load J/K from Q_FB and REQ_DATA;
    - clear the retry count;
    - go to DRIVE.
- DRIVE
  - J/K are held for exactly this cycle.
  - At the closing edge:
    - the bank updates;
    - J and K are cleared to 0;
    - go to CHECK.
- CHECK
  - J=K=0. Compare Q_FB with TARGET at the closing edge.
  - Equal: DONE=1 for the next cycle; go to IDLE.
  - Not equal and retry count < MAX_RETRY:
    - increment the retry count;
    - reload J/K from Q_FB and TARGET;
    - go to DRIVE.
  - Not equal and retry count == MAX_RETRY: ERR=1 for the next cycle; go to IDLE.
- Excitation per bit i (q=Q_FB[i], t=target[i]):
  - q==t: J=0, K=0.
  - q=0, t=1: J=1, K=0.
  - q=1, t=0: J=0, K=1.
- In default mode J and K are never both 1 on any bit.
- A target equal to the current Q_FB still runs DRIVE (all-zero J/K) and CHECK, then DONE.
- Retry counter width is clog2(MAX_RETRY+1). It saturates and never wraps.
- REQ_VALID and REQ_DATA are ignored outside IDLE.
- TARGET is stable from accept until return to IDLE.

## Timing
- Reset values:
  - state=IDLE, TARGET=0, retry=0.
  - J=0, K=0, DONE=0, ERR=0, BUSY=0.
  - REQ_READY=1.
- Reset asserted mid-DRIVE drops J/K to 0 immediately, with no partial pulse held.
- Accept at edge E0:
  - DRIVE in cycle E0–E1;
  - CHECK in cycle E1–E2;
  - DONE or ERR high in cycle E2–E3, together with REQ_READY=1.
- A new request may be accepted at E3, in the same cycle as the DONE pulse.
- Minimum 3 cycles per request. Each retry adds 2 cycles.
- Worst case to ERR: 3 + 2·MAX_RETRY cycles.
- DONE and ERR are never high together and never longer than one cycle.
- Q_FB must be settled one cycle after the driving edge. It is sampled only at the accept edge, the end of CHECK, and retry reload.

## Configuration
- JK_TOGGLE_EN
  - Defined: every bit with q!=t is driven J=1, K=1 (toggle); unchanged bits stay J=K=0. Toggle mode makes retries risky on a bank that already half-updated, but the same retry rules apply.
  - Undefined: set/reset excitation only, as in Operation. The 11 code is never produced.

## Test plan
- Reset, then idle: with RST high, J=K=0, DONE=ERR=BUSY=0 and REQ_READY=1. Release RST: outputs unchanged.
- Default mode, WIDTH=8:
  - Stimulus: Q_FB=0x0F, request 0xF0; model bank follows J/K.
  - J=0xF0 and K=0x0F for one cycle, then bank reads 0xF0.
  - DONE pulses in the cycle after CHECK, 3 cycles after accept.
- JK_TOGGLE_EN defined: Q_FB=0x3C, request 0x5A. J=K=0x66 for one cycle, then DONE.
- Stuck bit:
  - Stimulus: bank bit 0 forced to 0, request 0x01, MAX_RETRY=3.
  - Four DRIVE pulses with J=0x01, K=0x00, then ERR in cycle 9 after accept. No DONE.
- Reset mid-operation: assert RST during DRIVE. J/K go to 0 asynchronously, then state is IDLE and REQ_READY=1. A following request 0xAA completes with DONE.
